// File: rtl/div_cell.sv
// rtl/div_cell.sv - Q4.12 signed fixed-point divider, restoring shift-subtract, one quotient bit per cycle
// Optional build macro: DIV_SATURATE_EN (clamp out-of-range results instead of wrapping)
module div_cell #(
    parameter int         DATA_WIDTH      = 16,
    parameter int         FRACTIONAL_BITS = 12,
    parameter logic [3:0] IDLE            = 4'b0001,
    parameter logic [3:0] LOAD            = 4'b0010,
    parameter logic [3:0] CALCULATION     = 4'b0100,
    parameter logic [3:0] DONE            = 4'b1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] dividend,
    input  logic signed [DATA_WIDTH-1:0] divisor,
    output logic signed [DATA_WIDTH-1:0] quotient,
    output logic                         busy,
    output logic                         done,
    output logic                         div_by_zero
);

    // Numerator is |dividend| pre-scaled by the fractional bits; one iteration per numerator bit.
    localparam int NUM_W = DATA_WIDTH + FRACTIONAL_BITS;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_W - 1);

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

`ifdef DIV_SATURATE_EN
    // Largest magnitudes representable for a positive / negative result.
    localparam logic [NUM_W-1:0] POS_LIMIT = {{(NUM_W-DATA_WIDTH){1'b0}}, MAX_POS};
    localparam logic [NUM_W-1:0] NEG_LIMIT = {{(NUM_W-DATA_WIDTH){1'b0}}, MAX_NEG};
`endif

    typedef enum logic [3:0] {
        ST_IDLE = IDLE,
        ST_LOAD = LOAD,
        ST_CALC = CALCULATION,
        ST_DONE = DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_dividend;
    logic [DATA_WIDTH-1:0] r_divisor;
    // Numerator bits shift out of the top while quotient bits shift in at the bottom;
    // after the last iteration this register holds the full unsigned quotient.
    logic [NUM_W-1:0]      r_nq;
    logic [DATA_WIDTH-1:0] r_den;
    logic [DATA_WIDTH-1:0] r_rem;
    logic                  r_neg;
    logic                  r_dz;
    logic [CNT_W-1:0]      r_count;

    logic [DATA_WIDTH-1:0] w_dvd_mag;
    logic [DATA_WIDTH-1:0] w_dvs_mag;
    logic [DATA_WIDTH:0]   w_rem_shift;
    logic [DATA_WIDTH-1:0] w_rem_sub;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_result;

    // Operand magnitudes; the most negative value maps to its own unsigned magnitude.
    assign w_dvd_mag = r_dividend[DATA_WIDTH-1] ? (~r_dividend + ONE) : r_dividend;
    assign w_dvs_mag = r_divisor[DATA_WIDTH-1]  ? (~r_divisor + ONE)  : r_divisor;

    // Remainder stays below the divisor magnitude, so the shifted value fits one extra bit.
    assign w_rem_shift = {r_rem, r_nq[NUM_W-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_den});
    assign w_rem_sub   = w_rem_shift[DATA_WIDTH-1:0] - r_den;

    assign busy = (r_state != ST_IDLE);

    // Apply the result sign to the unsigned quotient and fit it to DATA_WIDTH.
    always_comb begin
        w_result = r_neg ? (~r_nq[DATA_WIDTH-1:0] + ONE) : r_nq[DATA_WIDTH-1:0];
`ifdef DIV_SATURATE_EN
        if (!r_neg && (r_nq > POS_LIMIT)) begin
            w_result = MAX_POS;
        end else if (r_neg && (r_nq > NEG_LIMIT)) begin
            w_result = MAX_NEG;
        end
`endif
    end

    // Control FSM and datapath; done/div_by_zero default low so they pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_nq        <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_count     <= '0;
            quotient    <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_nq    <= {w_dvd_mag, {FRACTIONAL_BITS{1'b0}}};
                    r_den   <= w_dvs_mag;
                    r_rem   <= '0;
                    r_neg   <= r_dividend[DATA_WIDTH-1] ^ r_divisor[DATA_WIDTH-1];
                    r_dz    <= (r_divisor == '0);
                    r_count <= '0;
                    r_state <= (r_divisor == '0) ? ST_DONE : ST_CALC;
                end
                ST_CALC: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_shift[DATA_WIDTH-1:0];
                    r_nq  <= {r_nq[NUM_W-2:0], w_ge};
                    if (r_count == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_dz) begin
                        quotient    <= r_dividend[DATA_WIDTH-1] ? MAX_NEG : MAX_POS;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= w_result;
                    end
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_cell.sv
// tb/tb_div_cell.sv - scoreboard testbench for div_cell
module tb_div_cell;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] q;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    div_cell dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one start pulse at the next edge and record the expected response.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic dz, input bit push);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = q;
        e.dz  = dz;
        e.cyc = cyc + 1 + ((b == 16'h0000) ? 2 : 30);
        if (push) sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 16'h00F0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic dz);
        issue(a, b, q, dz, 1'b1);
        wait_idle();
    endtask

    logic [15:0] exp_sat_7000;
    logic [15:0] exp_sat_7fff;

    initial begin
        int busy_cnt;
        int n0;
        exp_t e;

`ifdef DIV_SATURATE_EN
        exp_sat_7000 = 16'h7FFF;
        exp_sat_7fff = 16'h8000;
`else
        exp_sat_7000 = 16'h0000;
        exp_sat_7fff = 16'h1000;
`endif

        // Reset with start held high: nothing may be accepted.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'h2000;
        divisor  = 16'h1000;
        repeat (3) @(negedge clk);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);

        // First edge with rst low accepts the held start; busy lasts 30 cycles.
        rst   = 1'b0;
        e.q   = 16'h2000;
        e.dz  = 1'b0;
        e.cyc = cyc + 1 + 30;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        while (busy && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", busy_cnt, 32'd30);
        wait_idle();

        // Directed vectors.
        op(16'h1000, 16'h3000, 16'h0555, 1'b0);
        op(16'hF000, 16'h3000, 16'hFAAB, 1'b0);
        op(16'h7000, 16'h0100, exp_sat_7000, 1'b0);
        op(16'hF000, 16'h0000, 16'h8000, 1'b1);
        op(16'h1000, 16'h0000, 16'h7FFF, 1'b1);
        op(16'h0000, 16'h0000, 16'h7FFF, 1'b1);
        op(16'h0000, 16'h1234, 16'h0000, 1'b0);
        op(16'h8000, 16'h8000, 16'h1000, 1'b0);
        op(16'h8000, 16'h1000, 16'h8000, 1'b0);
        op(16'h7FFF, 16'hFFFF, exp_sat_7fff, 1'b0);
        op(16'h0800, 16'hF800, 16'hF000, 1'b0);
        op(16'hFFFF, 16'h0003, 16'hFAAB, 1'b0);

        // Start pulsed mid-operation with new operands must be ignored.
        issue(16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        dividend = 16'h4000;
        divisor  = 16'h0000;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_idle();

        // Start held high: two operations back to back, 31 cycles apart.
        @(negedge clk);
        dividend = 16'h2000;
        divisor  = 16'h1000;
        start    = 1'b1;
        n0 = cyc + 1;
        e.q = 16'h2000; e.dz = 1'b0; e.cyc = n0 + 30;
        sb.push_back(e);
        e.q = 16'hFAAB; e.dz = 1'b0; e.cyc = n0 + 31 + 30;
        sb.push_back(e);
        @(negedge clk);
        dividend = 16'hF000;
        divisor  = 16'h3000;
        while (cyc < n0 + 31) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset during calculation aborts without a done pulse.
        issue(16'h2000, 16'h1000, 16'h0000, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        op(16'h0800, 16'hF800, 16'hF000, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
